keyscan_ps2: RTL and testbench

KEYSCAN_PS2 -- requirements
Module: keyscan_ps2

---
 rtl/keyscan_ps2.sv | 236 +++++++++++++++++++++++
 tb/tb_keyscan_ps2.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/keyscan_ps2.sv
// Scans an 8x7 Dragon keyboard matrix, debounces it and reports key
// changes as PS/2 set-2 make/break byte sequences (device-to-host only).
module keyscan_ps2 #(
   parameter int SCAN_DWELL = 64,
   parameter int PS2_HALF   = 640,
   parameter int IDLE_CYC   = 800
) (
   input  logic       fastclk,
   input  logic       nRESET,
   output logic [7:0] col_n,
   input  logic [6:0] row_n,
   input  logic       ps2_clk_in,
   output logic       ps2_clk_oe,
   input  logic       ps2_data_in,
   output logic       ps2_data_oe,
   output logic       busy
);

   localparam logic [2:0] WAIT_IDLE = 3'd0;
   localparam logic [2:0] SETUP     = 3'd1;
   localparam logic [2:0] LOW       = 3'd2;
   localparam logic [2:0] HIGH_END  = 3'd3;
   localparam logic [2:0] GAP       = 3'd4;

   localparam int DW = $clog2(SCAN_DWELL + 1);
   localparam int HW = $clog2(PS2_HALF + 1);
   localparam int IW = $clog2(IDLE_CYC + 1);

   // Set-2 codes, one byte per key, index r*8+c from the LSB; 00 = no key.
   localparam logic [447:0] CODES = {
      64'h120000000076_6C5A, 64'h29746B72751A3522, 64'h1D2A3C2C1B2D154D,
      64'h44313A4B423B4333, 64'h342B242321321C0D, 64'h4A494E414C52463E,
      64'h3D362E25261E1645};
   localparam logic [55:0] EXT_MASK = 56'h02780000000000;

   logic       unused_data;
   assign unused_data = ps2_data_in;

   logic [6:0]    row_s1_reg, row_s2_reg;
   logic          clk_s1_reg, clk_s2_reg;
   logic [DW-1:0] dwell_reg;
   logic [2:0]    col_reg, col_next;
   logic [7:0]    col_n_reg;
   logic          last_dwell, pass_end;
   logic [55:0]   raw_reg, raw_full, last_pass_reg, stable_reg, reported_reg;
   logic [55:0]   reported_next, key_valid, diff;
   logic          pick_found;
   logic [5:0]    pick_idx;

   logic [2:0]    state_reg;
   logic          busy_reg;
   logic [5:0]    sel_idx_reg;
   logic          sel_brk_reg;
   logic [1:0]    byte_pos_reg;
   logic [3:0]    bit_idx_reg;
   logic [HW-1:0] half_cnt_reg;
   logic [IW-1:0] idle_cnt_reg;
   logic          half_end, sel_ext, last_byte, frame_bit, seq_done;
   logic [7:0]    sel_code, cur_byte;
   logic [1:0]    seq_len;

   always_ff @(posedge fastclk) begin
      if (!nRESET) begin
         row_s1_reg <= '1;
         row_s2_reg <= '1;
         clk_s1_reg <= 1'b1;
         clk_s2_reg <= 1'b1;
      end else begin
         row_s1_reg <= row_n;
         row_s2_reg <= row_s1_reg;
         clk_s1_reg <= ps2_clk_in;
         clk_s2_reg <= clk_s1_reg;
      end
   end

   assign last_dwell = (dwell_reg == DW'(SCAN_DWELL - 1));
   assign pass_end   = last_dwell && (col_reg == 3'd7);
   assign col_next   = last_dwell ? col_reg + 3'd1 : col_reg;

   genvar gi;
   generate
      for (gi = 0; gi < 56; gi++) begin : g_key
         assign key_valid[gi] = |CODES[gi*8 +: 8];
         assign raw_full[gi]  = (last_dwell && col_reg == 3'(gi % 8)) ?
                                row_s2_reg[gi / 8] : raw_reg[gi];
      end
   endgenerate

   always_ff @(posedge fastclk) begin
      if (!nRESET) begin
         dwell_reg     <= '0;
         col_reg       <= 3'd0;
         col_n_reg     <= 8'hFF;
         raw_reg       <= '1;
         last_pass_reg <= '1;
         stable_reg    <= '1;
      end else begin
         dwell_reg <= last_dwell ? '0 : dwell_reg + DW'(1);
         col_reg   <= col_next;
         col_n_reg <= ~(8'd1 << col_next);
         raw_reg   <= raw_full;
         if (pass_end) begin
            // A bit only moves when this pass and the previous one agree.
            last_pass_reg <= raw_full;
            stable_reg    <= (stable_reg & (raw_full ^ last_pass_reg)) |
                             (raw_full & ~(raw_full ^ last_pass_reg));
         end
      end
   end

   assign diff = (stable_reg ^ reported_reg) & key_valid;

   always_comb begin
      pick_found = 1'b0;
      pick_idx   = 6'd0;
      for (int i = 55; i >= 0; i--) begin
         if (diff[i]) begin
            pick_found = 1'b1;
            pick_idx   = 6'(i);
         end
      end
   end

   assign sel_code  = CODES[{sel_idx_reg, 3'b000} +: 8];
   assign sel_ext   = EXT_MASK[sel_idx_reg];
   assign seq_len   = 2'd1 + {1'b0, sel_ext} + {1'b0, sel_brk_reg};
   assign last_byte = (byte_pos_reg == seq_len - 2'd1);
   assign half_end  = (half_cnt_reg == HW'(PS2_HALF - 1));
   assign seq_done  = (state_reg == GAP) && last_byte;

   always_comb begin
      cur_byte = sel_code;
      if (sel_ext && byte_pos_reg == 2'd0)
         cur_byte = 8'hE0;
      else if (sel_brk_reg && byte_pos_reg == {1'b0, sel_ext})
         cur_byte = 8'hF0;
   end

   always_comb begin
      case (bit_idx_reg)
         4'd0:    frame_bit = 1'b0;
         4'd9:    frame_bit = ~^cur_byte;
         4'd10:   frame_bit = 1'b1;
         default: frame_bit = cur_byte[3'(bit_idx_reg - 4'd1)];
      endcase
   end

   always_comb begin
      reported_next = (reported_reg & key_valid) | (stable_reg & ~key_valid);
      if (seq_done)
         reported_next[sel_idx_reg] = sel_brk_reg;
   end

   always_ff @(posedge fastclk) begin
      if (!nRESET) begin
         state_reg    <= WAIT_IDLE;
         busy_reg     <= 1'b0;
         sel_idx_reg  <= 6'd0;
         sel_brk_reg  <= 1'b0;
         byte_pos_reg <= 2'd0;
         bit_idx_reg  <= 4'd0;
         half_cnt_reg <= '0;
         idle_cnt_reg <= '0;
         reported_reg <= '1;
      end else begin
         reported_reg <= reported_next;
         if (state_reg != WAIT_IDLE || !clk_s2_reg)
            idle_cnt_reg <= '0;
         else if (idle_cnt_reg != IW'(IDLE_CYC))
            idle_cnt_reg <= idle_cnt_reg + IW'(1);

         case (state_reg)
            WAIT_IDLE: begin
               half_cnt_reg <= '0;
               bit_idx_reg  <= 4'd0;
               if (!busy_reg && pick_found) begin
                  busy_reg     <= 1'b1;
                  sel_idx_reg  <= pick_idx;
                  sel_brk_reg  <= stable_reg[pick_idx];
                  byte_pos_reg <= 2'd0;
               end else if (busy_reg && idle_cnt_reg == IW'(IDLE_CYC)) begin
                  state_reg <= SETUP;
               end
            end
            SETUP: begin
               // The first two cycles still see our own LOW through the synchroniser.
               if (!clk_s2_reg && half_cnt_reg >= HW'(2)) begin
                  state_reg    <= WAIT_IDLE;
                  byte_pos_reg <= 2'd0;
                  half_cnt_reg <= '0;
               end else if (half_end) begin
                  state_reg    <= LOW;
                  half_cnt_reg <= '0;
               end else begin
                  half_cnt_reg <= half_cnt_reg + HW'(1);
               end
            end
            LOW: begin
               if (half_end) begin
                  half_cnt_reg <= '0;
                  if (bit_idx_reg == 4'd10) begin
                     state_reg <= HIGH_END;
                  end else begin
                     bit_idx_reg <= bit_idx_reg + 4'd1;
                     state_reg   <= SETUP;
                  end
               end else begin
                  half_cnt_reg <= half_cnt_reg + HW'(1);
               end
            end
            HIGH_END: begin
               if (half_end) begin
                  half_cnt_reg <= '0;
                  state_reg    <= GAP;
               end else begin
                  half_cnt_reg <= half_cnt_reg + HW'(1);
               end
            end
            GAP: begin
               state_reg <= WAIT_IDLE;
               if (last_byte)
                  busy_reg <= 1'b0;
               else
                  byte_pos_reg <= byte_pos_reg + 2'd1;
            end
            default: state_reg <= WAIT_IDLE;
         endcase
      end
   end

   assign col_n       = col_n_reg;
   assign busy        = busy_reg;
   assign ps2_clk_oe  = (state_reg == LOW);
   assign ps2_data_oe = (state_reg == SETUP || state_reg == LOW) && !frame_bit;

endmodule

// File: tb/tb_keyscan_ps2.sv
// Bench for keyscan_ps2: keyboard matrix model, PS/2 frame monitor and
// scoreboard of expected bytes pushed by the directed stimulus.
module tb_keyscan_ps2;

   localparam int DWELL = 4;
   localparam int HALF  = 8;
   localparam int IDLE  = 10;
   localparam int PASS  = 8 * DWELL;

   logic       fastclk, nRESET;
   logic [7:0] col_n;
   logic [6:0] row_n;
   logic       ps2_clk_in, ps2_clk_oe, ps2_data_in, ps2_data_oe, busy;
   logic [55:0] pressed;
   logic       inhibit;

   keyscan_ps2 #(.SCAN_DWELL(DWELL), .PS2_HALF(HALF), .IDLE_CYC(IDLE)) dut (
      .fastclk(fastclk), .nRESET(nRESET), .col_n(col_n), .row_n(row_n),
      .ps2_clk_in(ps2_clk_in), .ps2_clk_oe(ps2_clk_oe),
      .ps2_data_in(ps2_data_in), .ps2_data_oe(ps2_data_oe), .busy(busy));

   initial fastclk = 1'b0;
   always #5 fastclk = ~fastclk;

   always_comb begin
      for (int r = 0; r < 7; r++)
         row_n[r] = ~|(pressed[r*8 +: 8] & ~col_n);
   end
   assign ps2_clk_in  = ~(ps2_clk_oe | inhibit);
   assign ps2_data_in = ~ps2_data_oe;

   int n_checks = 0, n_pass = 0;
   int frames_seen = 0, exp_total = 0;
   logic [7:0] exp_q[$];
   logic busy_seen = 1'b0;

   task automatic chk(input string name, input bit ok, input int act, input int exp);
      n_checks++;
      if (ok) n_pass++;
      else $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", name, act, act, exp, exp);
   endtask

   task automatic push(input logic [7:0] b);
      exp_q.push_back(b);
      exp_total++;
   endtask

   // Monitor: rebuild frames from clk_oe rising edges, compare against the queue.
   logic        prev_clk_oe = 1'b0;
   int          nbits = 0, since_rise = 0, high_run = 0;
   logic [10:0] bits = '0;
   always @(negedge fastclk) begin
      if (busy) busy_seen = 1'b1;
      if (!prev_clk_oe && ps2_clk_oe) begin
         if (nbits == 0)
            chk("idle_gap", high_run >= IDLE, high_run, IDLE);
         bits[nbits] = ~ps2_data_oe;
         nbits++;
         since_rise = 0;
         if (nbits == 11) begin
            logic [7:0]  e;
            logic [10:0] ef;
            frames_seen++;
            nbits = 0;
            chk("frame_expected", exp_q.size() != 0, int'(bits), 0);
            if (exp_q.size() != 0) begin
               e  = exp_q.pop_front();
               ef = {1'b1, ~^e, e, 1'b0};
               chk("frame_bits", bits == ef, int'(bits), int'(ef));
               $display("frame %0d: byte %02h frame %03h", frames_seen, bits[8:1], bits);
            end
         end
      end else begin
         since_rise++;
         if (nbits > 0 && since_rise > 3 * HALF) nbits = 0;
      end
      high_run    = ps2_clk_in ? high_run + 1 : 0;
      prev_clk_oe = ps2_clk_oe;
   end

   task automatic cycles(input int n);
      repeat (n) @(negedge fastclk);
   endtask

   task automatic wait_frames(input string name);
      int t = 0;
      while (frames_seen < exp_total && t < 20000) begin
         @(negedge fastclk);
         t++;
      end
      chk(name, frames_seen >= exp_total, frames_seen, exp_total);
   endtask

   task automatic wait_busy_low(input string name);
      int t = 0;
      while (busy && t < 100) begin
         @(negedge fastclk);
         t++;
      end
      chk(name, !busy, int'(busy), 0);
   endtask

   task automatic wait_rises(input int n, input string name);
      int cnt = 0, t = 0;
      logic p = ps2_clk_oe;
      while (cnt < n && t < 5000) begin
         @(negedge fastclk);
         t++;
         if (ps2_clk_oe && !p) cnt++;
         p = ps2_clk_oe;
      end
      chk(name, cnt >= n, cnt, n);
   endtask

   initial begin
      int  t;
      bit  saw_oe;
      nRESET  = 1'b0;
      pressed = '0;
      inhibit = 1'b0;
      cycles(3);
      chk("rst_col_n", col_n == 8'hFF, col_n, 8'hFF);
      chk("rst_clk_oe", ps2_clk_oe == 1'b0, ps2_clk_oe, 0);
      chk("rst_data_oe", ps2_data_oe == 1'b0, ps2_data_oe, 0);
      chk("rst_busy", busy == 1'b0, busy, 0);
      nRESET = 1'b1;
      cycles(4 * PASS);
      chk("idle_no_busy", busy_seen == 1'b0, busy_seen, 0);

      // A make, then no repeat while held
      push(8'h1C);
      pressed[17] = 1'b1;
      wait_frames("a_make_frames");
      wait_busy_low("a_make_busy");
      cycles(4 * PASS);
      chk("a_no_extra", frames_seen == exp_total, frames_seen, exp_total);

      push(8'hF0); push(8'h1C);
      pressed[17] = 1'b0;
      wait_frames("a_break_frames");
      wait_busy_low("a_break_busy");

      push(8'hE0); push(8'h72);
      pressed[44] = 1'b1;
      wait_frames("down_make_frames");
      wait_busy_low("down_make_busy");

      // Down break: host inhibits during bit 4 SETUP of the F0 byte
      push(8'hE0);
      pressed[44] = 1'b0;
      wait_frames("down_brk_e0");
      wait_rises(4, "f0_bits_0_3");
      t = 0;
      while (ps2_clk_oe && t < 100) begin
         @(negedge fastclk);
         t++;
      end
      cycles(3);
      inhibit = 1'b1;
      t = 0;
      while ((ps2_clk_oe || ps2_data_oe) && t < 4) begin
         @(negedge fastclk);
         t++;
      end
      chk("inhibit_release", !(ps2_clk_oe || ps2_data_oe), t, 3);
      saw_oe = 1'b0;
      repeat (20) begin
         @(negedge fastclk);
         if (ps2_clk_oe || ps2_data_oe) saw_oe = 1'b1;
      end
      chk("inhibit_hold", saw_oe == 1'b0, saw_oe, 0);
      inhibit = 1'b0;
      push(8'hE0); push(8'hF0); push(8'h72);
      wait_frames("down_brk_restart");
      wait_busy_low("down_brk_busy");

      // One-pass glitch on key 26 must be filtered
      busy_seen = 1'b0;
      pressed[26] = 1'b1;
      cycles(PASS);
      pressed[26] = 1'b0;
      cycles(6 * PASS);
      chk("glitch_no_frame", frames_seen == exp_total, frames_seen, exp_total);
      chk("glitch_no_busy", busy_seen == 1'b0, busy_seen, 0);

      // Keys 9 and 0 pressed at the start of column 0 of one pass
      t = 0;
      while (col_n == 8'hFE && t < 100) begin @(negedge fastclk); t++; end
      while (col_n != 8'hFE && t < 200) begin @(negedge fastclk); t++; end
      push(8'h45); push(8'h46);
      pressed[0] = 1'b1;
      pressed[9] = 1'b1;
      wait_frames("two_key_frames");
      wait_busy_low("two_key_busy");

      // Release both, reset during the first break frame
      pressed[0] = 1'b0;
      pressed[9] = 1'b0;
      wait_rises(3, "brk_bits_0_2");
      nRESET = 1'b0;
      cycles(1);
      chk("midrst_clk_oe", ps2_clk_oe == 1'b0, ps2_clk_oe, 0);
      chk("midrst_data_oe", ps2_data_oe == 1'b0, ps2_data_oe, 0);
      chk("midrst_col_n", col_n == 8'hFF, col_n, 8'hFF);
      chk("midrst_busy", busy == 1'b0, busy, 0);
      cycles(3);
      nRESET = 1'b1;
      cycles(10 * PASS);
      chk("post_reset_quiet", frames_seen == exp_total, frames_seen, exp_total);
      chk("post_reset_busy", busy == 1'b0, busy, 0);
      chk("scoreboard_empty", exp_q.size() == 0, exp_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
